// File: rtl/inst_encoder.sv
// RV64I instruction assembler: field-level request in, 32-bit word out through a
// 2-entry FIFO. Illegal requests are replaced by a NOP and tagged with an error code.
module inst_encoder #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_fmt,
  input  logic [6:0]       in_opcode,
  input  logic [2:0]       in_funct3,
  input  logic [6:0]       in_funct7,
  input  logic [4:0]       in_rd,
  input  logic [4:0]       in_rs1,
  input  logic [4:0]       in_rs2,
  input  logic [63:0]      in_imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_inst,
  output logic             out_err,
  output logic [1:0]       out_err_code,
  output logic [CNT_W-1:0] enc_count
);

  typedef enum logic [2:0] {
    FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_SH, FMT_RSV
  } fmt_e;

  typedef enum logic [1:0] {
    ERR_NONE, ERR_RANGE, ERR_ALIGN, ERR_FMT
  } err_e;

  typedef struct packed {
    logic [31:0] inst;
    logic        err;
    err_e        code;
  } entry_t;

  localparam logic [31:0] NOP = 32'h0000_0013;

  // Signed-range tests: the bits above the field's sign bit must all match it.
  logic fits_12, fits_13, fits_21, fits_32, fits_sh;
  assign fits_12 = (&in_imm[63:11]) | ~(|in_imm[63:11]);
  assign fits_13 = (&in_imm[63:12]) | ~(|in_imm[63:12]);
  assign fits_21 = (&in_imm[63:20]) | ~(|in_imm[63:20]);
  assign fits_32 = (&in_imm[63:31]) | ~(|in_imm[63:31]);
  assign fits_sh = ~(|in_imm[63:6]);

  entry_t enc;
  logic [31:0] raw;
  logic        bad_range, bad_align, bad_fmt;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    raw       = '0;
    bad_range = 1'b0;
    bad_align = 1'b0;
    bad_fmt   = 1'b0;
    unique case (fmt_e'(in_fmt))
      FMT_R:  raw = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
      FMT_I: begin
        raw       = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
        bad_range = ~fits_12;
      end
      FMT_SH: begin
        raw       = {in_funct7[6:1], in_imm[5:0], in_rs1, in_funct3, in_rd, in_opcode};
        bad_range = ~fits_sh;
      end
      FMT_S: begin
        raw       = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
        bad_range = ~fits_12;
      end
      FMT_B: begin
        raw       = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                     in_imm[4:1], in_imm[11], in_opcode};
        bad_range = ~fits_13;
        bad_align = in_imm[0];
      end
      FMT_U: begin
        raw       = {in_imm[31:12], in_rd, in_opcode};
        bad_range = ~fits_32;
        bad_align = |in_imm[11:0];
      end
      FMT_J: begin
        raw       = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
        bad_range = ~fits_21;
        bad_align = in_imm[0];
      end
      default: bad_fmt = 1'b1;
    endcase

    enc.inst = raw;
    enc.err  = 1'b0;
    enc.code = ERR_NONE;
    if (bad_fmt) begin
      enc = '{inst: NOP, err: 1'b1, code: ERR_FMT};
    end else if (bad_align) begin
      enc = '{inst: NOP, err: 1'b1, code: ERR_ALIGN};
    end else if (bad_range) begin
      enc = '{inst: NOP, err: 1'b1, code: ERR_RANGE};
    end
  end

  // Output FIFO
  entry_t     mem [2];
  logic       wr_ptr, rd_ptr;
  logic [1:0] count, count_next;
  logic       push, pop;

  assign out_valid = (count != 2'd0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_comb begin
    count_next = count;
    if (push && !pop)      count_next = count + 2'd1;
    else if (pop && !push) count_next = count - 2'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count     <= 2'd0;
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      in_ready  <= 1'b0;
      enc_count <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      count    <= count_next;
      in_ready <= (count_next != 2'd2);
      if (push) wr_ptr <= ~wr_ptr;
      if (pop) begin
        rd_ptr    <= ~rd_ptr;
        enc_count <= enc_count + CNT_W'(1);
      end
    end
  end

  // NOTE: storage is deliberately not reset; the outputs are masked by out_valid instead.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= enc;
  end

  entry_t head;
  assign head         = mem[rd_ptr];
  assign out_inst     = out_valid ? head.inst : 32'h0;
  assign out_err      = out_valid & head.err;
  assign out_err_code = out_valid ? head.code : ERR_NONE;

endmodule
